// File: rtl/moving_sum_if.sv
// Sample/result bundle for the moving_sum boxcar summer.
//   master: producer side, drives din_valid, din, clear; observes dout, dout_valid, full
//   slave : summer side, the mirror image
// DATA_WIDTH/OUT_WIDTH must match the parameters of the attached moving_sum.
interface moving_sum_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 12
);
  logic                         din_valid;
  logic signed [DATA_WIDTH-1:0] din;
  logic                         clear;
  logic signed [OUT_WIDTH-1:0]  dout;
  logic                         dout_valid;
  logic                         full;

  modport master (
    output din_valid, din, clear,
    input  dout, dout_valid, full
  );

  modport slave (
    input  din_valid, din, clear,
    output dout, dout_valid, full
  );
endinterface

// File: rtl/moving_sum.sv
// Sliding-window (boxcar) summer: running sum of the last 2^LOG2_LEN accepted
// signed samples, held in a register circular buffer. Full-precision output,
// no saturation (the downstream stage clamps).
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset, deassertion synchronised internally
//   bus    - moving_sum_if.slave: din_valid/din/clear in, dout/dout_valid/full out
module moving_sum #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOG2_LEN   = 4,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH + LOG2_LEN
) (
  input logic         clk,
  input logic         resetn,
  moving_sum_if.slave bus
);

  localparam int unsigned Len = 1 << LOG2_LEN;

  if (LOG2_LEN < 1 || LOG2_LEN > 8) begin : g_bad_len
    $error("moving_sum: LOG2_LEN out of range 1..8");
  end
  if (OUT_WIDTH < DATA_WIDTH + LOG2_LEN) begin : g_bad_width
    $error("moving_sum: OUT_WIDTH too small for exact sum");
  end

  // Reset deassertion synchroniser; datapath only acts once run is high.
  logic [1:0] rst_sync_q;
  logic       run;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  logic signed [DATA_WIDTH-1:0] buf_q [Len];
  logic signed [DATA_WIDTH-1:0] buf_d [Len];
  logic signed [OUT_WIDTH-1:0]  sum_q, sum_d;
  logic [LOG2_LEN-1:0]          wr_ptr_q, wr_ptr_d;
  logic [LOG2_LEN:0]            fill_q, fill_d;
  logic                         dout_valid_q, dout_valid_d;
  logic signed [OUT_WIDTH-1:0]  din_ext, old_ext;

  assign din_ext = OUT_WIDTH'(bus.din);
  assign old_ext = OUT_WIDTH'(buf_q[wr_ptr_q]);

  always_comb begin
    buf_d        = buf_q;
    sum_d        = sum_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    dout_valid_d = 1'b0;
    if (run && bus.clear) begin
      // Flush wins over a simultaneous sample, which is dropped.
      buf_d    = '{default: '0};
      sum_d    = '0;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (run && bus.din_valid) begin
      // Empty slots hold 0, so the subtract is harmless while filling.
      sum_d            = sum_q + din_ext - old_ext;
      buf_d[wr_ptr_q]  = bus.din;
      wr_ptr_d         = wr_ptr_q + LOG2_LEN'(1);
      dout_valid_d     = 1'b1;
      if (!fill_q[LOG2_LEN]) begin
        fill_d = fill_q + (LOG2_LEN+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_q        <= '{default: '0};
      sum_q        <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      sum_q        <= sum_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // fill saturates at exactly 2^LOG2_LEN, so its MSB is the full flag.
  assign bus.dout       = sum_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.full       = fill_q[LOG2_LEN];

endmodule

// File: tb/tb_moving_sum.sv
// Directed bench for moving_sum with default parameters (N = 16).
module tb_moving_sum;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  moving_sum_if #(.DATA_WIDTH(8), .OUT_WIDTH(12)) bus ();

  moving_sum #(.DATA_WIDTH(8), .LOG2_LEN(4), .OUT_WIDTH(12)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.clear     = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (bus.dout !== 12'sd0) begin errors++; $display("FAIL reset_dout got %0d want 0", bus.dout); end
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", bus.dout_valid); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    end
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (bus.dout !== 12'sd0) begin errors++; $display("FAIL post_reset_dout got %0d want 0", bus.dout); end
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL post_reset_dv got %b want 0", bus.dout_valid); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL post_reset_full got %b want 0", bus.full); end
    end
  endtask

  task automatic test_step();
    bus.din_valid = 1'b1;
    bus.din       = 8'sd1;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      checks++; if (bus.dout !== 12'(k > 16 ? 16 : k)) begin errors++; $display("FAIL step_dout[%0d] got %0d want %0d", k, bus.dout, (k > 16 ? 16 : k)); end
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL step_dv[%0d] got %b want 1", k, bus.dout_valid); end
      checks++; if (bus.full !== (k >= 16)) begin errors++; $display("FAIL step_full[%0d] got %b want %b", k, bus.full, (k >= 16)); end
    end
  endtask

  task automatic test_step_change();
    bus.din_valid = 1'b1;
    bus.din       = 8'sd18;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      checks++; if (bus.dout !== 12'(16 + 17 * (k > 16 ? 16 : k))) begin errors++; $display("FAIL stepchg_dout[%0d] got %0d want %0d", k, bus.dout, 16 + 17 * (k > 16 ? 16 : k)); end
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL stepchg_full[%0d] got %b want 1", k, bus.full); end
    end
  endtask

  task automatic test_clear();
    // Running sum is 288 and full here; the simultaneous sample is dropped.
    bus.din_valid = 1'b1;
    bus.din       = 8'sd7;
    bus.clear     = 1'b1;
    cyc();
    checks++; if (bus.dout !== 12'sd0) begin errors++; $display("FAIL clear_dout got %0d want 0", bus.dout); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL clear_full got %b want 0", bus.full); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL clear_dv got %b want 0", bus.dout_valid); end
    bus.clear = 1'b0;
    cyc();
    checks++; if (bus.dout !== 12'sd7) begin errors++; $display("FAIL after_clear_dout got %0d want 7", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL after_clear_dv got %b want 1", bus.dout_valid); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL after_clear_full got %b want 0", bus.full); end
    bus.din_valid = 1'b0;
    cyc();
    checks++; if (bus.dout !== 12'sd7) begin errors++; $display("FAIL hold_dout got %0d want 7", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL hold_dv got %b want 0", bus.dout_valid); end
  endtask

  task automatic test_extremes();
    bus.clear     = 1'b1;
    bus.din_valid = 1'b0;
    cyc();
    bus.clear     = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = -8'sd128;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      checks++; if (bus.dout !== 12'(-128 * k)) begin errors++; $display("FAIL neg_dout[%0d] got %0d want %0d", k, bus.dout, -128 * k); end
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL neg_full got %b want 1", bus.full); end
    bus.din = 8'sd127;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      checks++; if (bus.dout !== 12'(-2048 + 255 * k)) begin errors++; $display("FAIL pos_dout[%0d] got %0d want %0d", k, bus.dout, -2048 + 255 * k); end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic test_gapped();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    bus.din   = 8'sd5;
    for (int j = 1; j <= 6; j++) begin
      bus.din_valid = 1'b1;
      cyc();
      checks++; if (bus.dout !== 12'(5 * j)) begin errors++; $display("FAIL gap_dout[%0d] got %0d want %0d", j, bus.dout, 5 * j); end
      checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL gap_dv[%0d] got %b want 1", j, bus.dout_valid); end
      bus.din_valid = 1'b0;
      cyc();
      checks++; if (bus.dout !== 12'(5 * j)) begin errors++; $display("FAIL gap_hold[%0d] got %0d want %0d", j, bus.dout, 5 * j); end
      checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL gap_idle_dv[%0d] got %b want 0", j, bus.dout_valid); end
    end
  endtask

  task automatic test_async_reset();
    bus.din_valid = 1'b1;
    bus.din       = 8'sd9;
    cyc();
    // Drop reset between edges; outputs must clear without a clock.
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (bus.dout !== 12'sd0) begin errors++; $display("FAIL async_dout got %0d want 0", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL async_dv got %b want 0", bus.dout_valid); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL async_full got %b want 0", bus.full); end
    cyc();
    resetn = 1'b1;
    // First edge after release must not accept.
    cyc();
    checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL sync_first_dv got %b want 0", bus.dout_valid); end
    checks++; if (bus.dout !== 12'sd0) begin errors++; $display("FAIL sync_first_dout got %0d want 0", bus.dout); end
    bus.din_valid = 1'b0;
    cyc();
    cyc();
    bus.din_valid = 1'b1;
    bus.din       = 8'sd3;
    cyc();
    bus.din_valid = 1'b0;
    checks++; if (bus.dout !== 12'sd3) begin errors++; $display("FAIL recover_dout got %0d want 3", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL recover_dv got %b want 1", bus.dout_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_step();
    test_step_change();
    test_clear();
    test_extremes();
    test_gapped();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
